// File: rtl/wallclock_pkg.sv
// rtl/wallclock_pkg.sv - shared constants and slot helpers for the WallClock display back-end
package wallclock_pkg;

  typedef enum logic [1:0] {
    SLOT_MIN1 = 2'd0,
    SLOT_MIN2 = 2'd1,
    SLOT_HRS1 = 2'd2,
    SLOT_HRS2 = 2'd3
  } slot_t;

  // Active-low {g,f,e,d,c,b,a} cathode patterns
  localparam logic [6:0] SEG_0 = ~7'h3F;
  localparam logic [6:0] SEG_1 = ~7'h06;
  localparam logic [6:0] SEG_2 = ~7'h5B;
  localparam logic [6:0] SEG_3 = ~7'h4F;
  localparam logic [6:0] SEG_4 = ~7'h66;
  localparam logic [6:0] SEG_5 = ~7'h6D;
  localparam logic [6:0] SEG_6 = ~7'h7D;
  localparam logic [6:0] SEG_7 = ~7'h07;
  localparam logic [6:0] SEG_8 = ~7'h7F;
  localparam logic [6:0] SEG_9 = ~7'h6F;
  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  localparam logic [7:0] DRV_MIN1 = 8'b1111_1110;
  localparam logic [7:0] DRV_MIN2 = 8'b1111_1101;
  localparam logic [7:0] DRV_HRS1 = 8'b1111_1011;
  localparam logic [7:0] DRV_HRS2 = 8'b1111_0111;
  localparam logic [7:0] DRV_OFF  = 8'hFF;

  function automatic logic [7:0] slot_driver(input slot_t slot);
    logic [7:0] drv;
    case (slot)
      SLOT_MIN1: drv = DRV_MIN1;
      SLOT_MIN2: drv = DRV_MIN2;
      SLOT_HRS1: drv = DRV_HRS1;
      SLOT_HRS2: drv = DRV_HRS2;
      default:   drv = DRV_OFF;
    endcase
    return drv;
  endfunction

endpackage

// File: rtl/bcd_to_seg.sv
// rtl/bcd_to_seg.sv - combinational BCD to active-low 7-segment decoder, blank above 9
module bcd_to_seg
  import wallclock_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_OFF;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seven_seg_scan.sv
// rtl/seven_seg_scan.sv - multiplexed 4-digit common-anode scan with dead-time and PWM dimming
module seven_seg_scan
  import wallclock_pkg::*;
#(
  parameter int SCAN_W      = 17,
  parameter int DEAD_CYCLES = 4,
  parameter int LZ_BLANK    = 0
) (
  input  logic       CLK100MHZ,
  input  logic       RESET_BTN,
  input  logic [3:0] hrs2,
  input  logic [3:0] hrs1,
  input  logic [3:0] min2,
  input  logic [3:0] min1,
  input  logic [7:0] pwm_in,
  output logic [7:0] SevenSegment,
  output logic [7:0] SegmentDrivers
);

  logic [SCAN_W-1:0] scan_cnt;
  slot_t             slot;
  logic              snap_pending;
  logic [3:0]        sh_hrs2, sh_hrs1, sh_min2, sh_min1;

  logic              slot_wrap;
  logic              frame_wrap;
  logic [7:0]        phase;
  logic [3:0]        digit;
  logic [6:0]        digit_seg;
  logic              lit;

  assign slot_wrap  = &scan_cnt;
  assign frame_wrap = slot_wrap && (slot == SLOT_HRS2);
  assign phase      = scan_cnt[SCAN_W-1 -: 8];

  always_comb begin
    digit = sh_min1;
    case (slot)
      SLOT_MIN1: digit = sh_min1;
      SLOT_MIN2: digit = sh_min2;
      SLOT_HRS1: digit = sh_hrs1;
      SLOT_HRS2: digit = sh_hrs2;
      default:   digit = sh_min1;
    endcase
  end

  // Leading-zero suppression makes slot 3 behave exactly like an unlit cycle
  always_comb begin
    lit = (scan_cnt >= SCAN_W'(DEAD_CYCLES)) && (phase >= pwm_in);
    if ((LZ_BLANK != 0) && (slot == SLOT_HRS2) && (sh_hrs2 == 4'd0))
      lit = 1'b0;
  end

  bcd_to_seg u_bcd_to_seg (
    .bcd (digit),
    .seg (digit_seg)
  );

  always_ff @(posedge CLK100MHZ) begin
    if (RESET_BTN) begin
      scan_cnt <= '0;
      slot     <= SLOT_MIN1;
    end else begin
      scan_cnt <= scan_cnt + SCAN_W'(1);
      if (slot_wrap)
        slot <= slot_t'(slot + 2'd1);
    end
  end

  // Shadow copy only at frame boundaries so a frame never mixes two times
  always_ff @(posedge CLK100MHZ) begin
    if (RESET_BTN) begin
      snap_pending <= 1'b1;
      sh_hrs2      <= 4'd0;
      sh_hrs1      <= 4'd0;
      sh_min2      <= 4'd0;
      sh_min1      <= 4'd0;
    end else begin
      snap_pending <= 1'b0;
      if (snap_pending || frame_wrap) begin
        sh_hrs2 <= hrs2;
        sh_hrs1 <= hrs1;
        sh_min2 <= min2;
        sh_min1 <= min1;
      end
    end
  end

  always_ff @(posedge CLK100MHZ) begin
    if (RESET_BTN) begin
      SegmentDrivers <= DRV_OFF;
      SevenSegment   <= SEG_BLANK;
    end else if (lit) begin
      SegmentDrivers <= slot_driver(slot);
      SevenSegment   <= (digit > 4'd9) ? SEG_BLANK : {1'b0, digit_seg};
    end else begin
      SegmentDrivers <= DRV_OFF;
      SevenSegment   <= SEG_BLANK;
    end
  end

endmodule
